// File: rtl/fmac_pkg.sv
// Shared definitions for the FMAC accumulate stage.
//   PROD_W       product width delivered by the 8x8 Booth multiplier
//   acc_state_t  accumulator FSM states
//   sat_max/min  signed saturation limits for a given width, returned in 64 bits
//                (callers truncate to their own width)
package fmac_pkg;

    localparam int unsigned PROD_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } acc_state_t;

    function automatic logic [63:0] sat_max(int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Bitwise inverse of 2^(w-1)-1 is -2^(w-1) in two's complement.
    function automatic logic [63:0] sat_min(int unsigned width);
        return ~sat_max(width);
    endfunction

endpackage

// File: rtl/fmac_acc_add.sv
// Combinational accumulate adder: sign-extends the product, adds it to the
// running sum and flags signed overflow.
// Optional feature macro: FMAC_SAT_EN (clamp to the signed limits on overflow;
// otherwise the sum wraps).
// Ports:
//   acc   in   ACC_W   current accumulator value
//   prod  in   PROD_W  two's-complement product
//   sum   out  ACC_W   acc + sext(prod), clamped when saturation is enabled
//   ovf   out  1       signed overflow of this addition
module fmac_acc_add #(
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned PROD_W = fmac_pkg::PROD_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);
    import fmac_pkg::*;

    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] raw;

    always_comb begin
        ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        raw = acc + ext;
        // Same-sign addends producing a result of the other sign.
        ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
`ifdef FMAC_SAT_EN
        if (ovf) begin
            sum = acc[ACC_W-1] ? ACC_W'(sat_min(ACC_W)) : ACC_W'(sat_max(ACC_W));
        end else begin
            sum = raw;
        end
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/fmac_accumulator.sv
// FMAC accumulate stage: sums the signed products of one group and presents
// the registered result with a sticky overflow flag.
// Optional feature macro: FMAC_SAT_EN (saturating accumulation, see fmac_acc_add).
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   prod         product beat; prod_valid/prod_first/prod_last qualify it
//   prod_ready   beat accepted this cycle (combinational from state and res_ready)
//   res, res_ovf registered group sum and sticky overflow
//   res_valid    result present; res_ready consumes it
module fmac_accumulator #(
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned PROD_W = fmac_pkg::PROD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_valid,
    input  logic              prod_first,
    input  logic              prod_last,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  res,
    output logic              res_ovf,
    output logic              res_valid,
    input  logic              res_ready
);
    import fmac_pkg::*;

    acc_state_t       state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [ACC_W-1:0] res_q;
    logic             res_ovf_q;
    logic             res_valid_q;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             accept;
    logic             load_first;

    assign prod_ready = (state_q != StHold) || res_ready;
    assign accept     = prod_valid && prod_ready;
    // Outside ACCUM (including HOLD being drained this cycle) a beat starts a group.
    assign load_first = (state_q != StAccum) || prod_first;
    assign prod_ext   = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    fmac_acc_add #(
        .ACC_W (ACC_W),
        .PROD_W(PROD_W)
    ) u_add (
        .acc (acc_q),
        .prod(prod),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        acc_d = add_sum;
        ovf_d = ovf_q | add_ovf;
        if (load_first) begin
            acc_d = prod_ext;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            res_q       <= '0;
            res_ovf_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            if (state_q == StHold && res_ready) begin
                res_valid_q <= 1'b0;
                state_q     <= StIdle;
            end
            // A beat accepted in the same cycle overrides the drain above.
            if (accept) begin
                acc_q <= acc_d;
                ovf_q <= ovf_d;
                if (prod_last) begin
                    res_q       <= acc_d;
                    res_ovf_q   <= ovf_d;
                    res_valid_q <= 1'b1;
                    state_q     <= StHold;
                end else begin
                    state_q     <= StAccum;
                end
            end
        end
    end

    assign res       = res_q;
    assign res_ovf   = res_ovf_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_fmac_accumulator.sv
// Scoreboard bench for fmac_accumulator at ACC_W = 17 so overflow is easy to reach.
module tb_fmac_accumulator;

    localparam int unsigned ACC_W  = 17;
    localparam int unsigned PROD_W = 16;
    localparam longint MAXV = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (ACC_W - 1));
    localparam longint SPAN = longint'(1) << ACC_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PROD_W-1:0] prod = '0;
    logic              prod_valid = 1'b0;
    logic              prod_first = 1'b0;
    logic              prod_last = 1'b0;
    logic              prod_ready;
    logic [ACC_W-1:0]  res;
    logic              res_ovf;
    logic              res_valid;
    logic              res_ready = 1'b0;

    typedef struct packed {
        logic [ACC_W-1:0] res;
        logic             ovf;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail = 0;
    bit     rr_random = 1'b0;

    // Reference model: exact integer arithmetic on the group sum.
    longint m_acc = 0;
    bit     m_ovf = 1'b0;
    bit     m_in_group = 1'b0;

    always #5 clk = ~clk;

    fmac_accumulator #(
        .ACC_W(ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prod      (prod),
        .prod_valid(prod_valid),
        .prod_first(prod_first),
        .prod_last (prod_last),
        .prod_ready(prod_ready),
        .res       (res),
        .res_ovf   (res_ovf),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint fit(input longint t);
        longint r;
        if (t <= MAXV && t >= MINV) return t;
`ifdef FMAC_SAT_EN
        return (t > MAXV) ? MAXV : MINV;
`else
        r = (t - MINV) % SPAN;
        if (r < 0) r += SPAN;
        return r + MINV;
`endif
    endfunction

    task automatic model_beat(input logic [PROD_W-1:0] p, input bit first, input bit last);
        longint term;
        longint t;
        exp_t   e;
        term = longint'(signed'(p));
        if (!m_in_group || first) begin
            m_acc = term;
            m_ovf = 1'b0;
        end else begin
            t = m_acc + term;
            if (t > MAXV || t < MINV) m_ovf = 1'b1;
            m_acc = fit(t);
        end
        if (last) begin
            e.res = m_acc[ACC_W-1:0];
            e.ovf = m_ovf;
            sb.push_back(e);
            m_in_group = 1'b0;
        end else begin
            m_in_group = 1'b1;
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the beat is taken.
    task automatic send_beat(input logic [PROD_W-1:0] p, input bit first, input bit last);
        int waited;
        bit ok;
        waited = 0;
        ok = 1'b0;
        prod = p;
        prod_first = first;
        prod_last = last;
        prod_valid = 1'b1;
        while (!ok && waited < 50) begin
            @(negedge clk);
            if (prod_ready) ok = 1'b1;
            else waited++;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: beat 0x%0h not accepted, expected within 50 cycles", p);
        end else begin
            model_beat(p, first, last);
        end
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        prod_first = 1'b0;
        prod_last = 1'b0;
        if (ok && last) check("res_valid_latency", longint'(res_valid), 1);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic check_held(input string name, input longint exp_res, input bit exp_ovf);
        check({name, "_valid"}, longint'(res_valid), 1);
        check({name, "_res"}, longint'(res), exp_res);
        check({name, "_ovf"}, longint'(res_ovf), longint'(exp_ovf));
    endtask

    // Monitor: pops an expectation whenever a result is consumed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got result 0x%0h, expected none", res);
                end else begin
                    e = sb.pop_front();
                    check("sb_res", longint'(res), longint'(e.res));
                    check("sb_ovf", longint'(res_ovf), longint'(e.ovf));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_random) res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int waited;
        logic [PROD_W-1:0] p;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_res_valid", longint'(res_valid), 0);
        check("rst_res", longint'(res), 0);
        check("rst_res_ovf", longint'(res_ovf), 0);
        check("rst_prod_ready", longint'(prod_ready), 1);

        // Basic sum, then backpressure on the result.
        send_beat(16'h7FFF, 1'b1, 1'b0);
        send_beat(16'h7FFF, 1'b0, 1'b0);
        send_beat(16'h8000, 1'b0, 1'b1);
        check_held("basic", 32766, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_res_valid", longint'(res_valid), 1);
            check("bp_prod_ready", longint'(prod_ready), 0);
            check("bp_res_stable", longint'(res), 32766);
        end
        res_ready = 1'b1;
        send_beat(16'd9, 1'b1, 1'b1);
        check_held("bp_next", 9, 1'b0);
        consume();

        // Negative terms.
        send_beat(16'hFFFD, 1'b1, 1'b0);
        send_beat(16'h0002, 1'b0, 1'b1);
        check_held("neg", 17'h1FFFF, 1'b0);
        consume();

        // Restart mid-group and one-term group.
        send_beat(16'd10, 1'b1, 1'b0);
        send_beat(16'd20, 1'b0, 1'b0);
        send_beat(16'd7, 1'b1, 1'b0);
        send_beat(16'd1, 1'b0, 1'b1);
        check_held("restart", 8, 1'b0);
        consume();
        send_beat(16'd5, 1'b1, 1'b1);
        check_held("single", 5, 1'b0);
        consume();

        // Overflow.
        send_beat(16'h7FFF, 1'b1, 1'b0);
        send_beat(16'h7FFF, 1'b0, 1'b0);
        send_beat(16'h7FFF, 1'b0, 1'b1);
`ifdef FMAC_SAT_EN
        check_held("ovf_sat", 17'h0FFFF, 1'b1);
`else
        check_held("ovf_wrap", 17'h17FFD, 1'b1);
`endif
        consume();

        // Reset mid-group.
        send_beat(16'd100, 1'b1, 1'b0);
        send_beat(16'd200, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_in_group = 1'b0;
        sb.delete();
        check("midrst_res_valid", longint'(res_valid), 0);
        check("midrst_res", longint'(res), 0);
        check("midrst_prod_ready", longint'(prod_ready), 1);
        send_beat(16'd5, 1'b1, 1'b1);
        check_held("after_rst", 5, 1'b0);
        consume();

        // Randomized traffic with random backpressure.
        rr_random = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            case ($urandom_range(0, 3))
                0: p = 16'h7FFF;
                1: p = 16'h8000;
                default: p = 16'($urandom);
            endcase
            send_beat(p, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
        end
        send_beat(16'($urandom), 1'b0, 1'b1);

        // Drain outstanding results.
        rr_random = 1'b0;
        @(posedge clk);
        #2;
        res_ready = 1'b1;
        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        check("drain_sb_empty", longint'(sb.size()), 0);
        check("drain_res_valid", longint'(res_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
